chip_link_tx: RTL
=================

// Module: chip_link_tx
// PURPOSE
//   Chip-to-chip link transmitter: takes one 64-bit spike/config packet and serialises it
//   MSB-first as four 16-bit flits on a send_data_* port.
//   Each flit uses a four-phase valid/ready handshake with even parity.
//   A receiver error flag triggers retransmission of that flit.
//   Sits between the router's off-chip output FIFO and the chip pads, once per E/N/W/S port.
// PARAMETERS
//   PKT_W           64  packet width (FW+CONNECT_WIDTH); must be a multiple of CHIPDATA_WIDTH
//   CHIPDATA_WIDTH  16  flit width on the link
//   MAX_RETRY       3   retransmissions allowed per flit before the packet is dropped
//   (local) FLITS = PKT_W/CHIPDATA_WIDTH = 4; CNT_W = clog2(FLITS)
// PORTS
//   clk              in   1                clock
//   rst              in   1                synchronous reset, active-high
//   pkt_in           in   PKT_W            packet to send
//   pkt_valid        in   1                pkt_in valid
//   pkt_ready        out  1                packet accepted when pkt_valid&&pkt_ready
//   send_data_out    out  CHIPDATA_WIDTH   flit data
//   send_data_valid  out  1                flit valid (four-phase request)
//   send_data_par    out  1                even parity: ^send_data_out
//   send_data_ready  in   1                receiver acknowledge (four-phase)
//   send_data_err    in   1                parity error reported by receiver; sampled with ready
//   busy             out  1                packet in flight
//   pkt_drop         out  1                1-cycle pulse: packet aborted after MAX_RETRY
// BEHAVIOUR
//   Reset: state=IDLE; pkt_ready=1 only after reset releases (0 while rst=1).
//     send_data_out=0, send_data_valid=0, send_data_par=0, busy=0, pkt_drop=0.
//     Flit index and retry count are 0. Reset mid-packet abandons it; no further flits are sent.
//   pkt_ready = (state==IDLE) && !rst. On accept, pkt_in is latched into shift reg; flit idx=0.
//   FSM:
//     IDLE:    on accept -> REQ next cycle. Outputs driven from registers, so valid rises
//              1 cycle after accept with flit0 = pkt[63:48] and its parity.
//     REQ:     valid=1; data/par held stable. Wait send_data_ready==1, then sample err.
//              Goes to REL with flag bad=err.
//     REL:     valid=0. Wait send_data_ready==0. Then:
//                !bad, idx<FLITS-1  -> idx++, retry=0, REQ with next flit
//                !bad, idx==FLITS-1 -> IDLE (pkt_ready=1 next cycle)
//                 bad, retry<MAX_RETRY -> retry++, REQ with same flit
//                 bad, retry==MAX_RETRY -> pkt_drop=1 for one cycle, IDLE
//   Flit order: pkt[63:48], [47:32], [31:16], [15:0].
//   Data changes only on the REL->REQ edge, never while valid=1.
//   send_data_ready already 1 on entering REQ (stale ack): do not advance.
//     REQ is reached only from IDLE/REL with ready=0, so ready=1 on entry is ignored
//     until it has been observed 0.
//   Minimum flit period 2 cycles plus receiver latency. busy = (state!=IDLE).
//   No timeout: REQ waits indefinitely for ready.
// CONFIGURATION
//   CLTX_RETRY_EN defined: error retransmission and pkt_drop work as above.
//   CLTX_RETRY_EN undefined: send_data_err ignored; bad is always 0; every flit advances.
//     pkt_drop tied to 0; retry counter not built.
// TESTING
//   1 Reset, pkt 0x0123_4567_89AB_CDEF. Receiver acks each flit 2 cycles after valid.
//     -> flits 0x0123,0x4567,0x89AB,0xCDEF; par=0,0,0,0; pkt_ready returns 1.
//   2 Flit 0xFFFE (odd weight) -> par=1. Flit 0x0000 -> par=0. Data stable while valid=1.
//   3 err=1 on flit 2 (0x89AB) once, CLTX_RETRY_EN set.
//     -> 0x89AB re-sent, then 0xCDEF; 5 handshakes total; pkt_drop=0.
//   4 err=1 on every ack of flit 0, CLTX_RETRY_EN set.
//     -> flit0 sent 4 times (1+MAX_RETRY); pkt_drop pulses 1 cycle; IDLE; no flit1.
//   5 Same stimulus as 4 without CLTX_RETRY_EN.
//     -> 4 distinct flits sent once each; pkt_drop never 1.
//   6 rst=1 while in REQ on flit 1 -> next cycle valid=0, busy=0.
//     After release, new pkt 0xAAAA_5555_AAAA_5555 sends 4 flits correctly.

Source files
------------

// File: rtl/chip_link_tx.sv
// Chip-to-chip link transmitter: serialises one PKT_W packet MSB-first into
// CHIPDATA_WIDTH flits, each sent with a four-phase valid/ready handshake and
// even parity. Optional feature macro CLTX_RETRY_EN enables retransmission of a
// flit the receiver flagged with send_data_err, and drops the packet (pkt_drop
// pulse) once MAX_RETRY retransmissions of one flit have all failed.
module chip_link_tx #(
  parameter int PKT_W          = 64,
  parameter int CHIPDATA_WIDTH = 16,
  parameter int MAX_RETRY      = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [PKT_W-1:0]          pkt_in,
  input  logic                      pkt_valid,
  output logic                      pkt_ready,
  output logic [CHIPDATA_WIDTH-1:0] send_data_out,
  output logic                      send_data_valid,
  output logic                      send_data_par,
  input  logic                      send_data_ready,
  input  logic                      send_data_err,
  output logic                      busy,
  output logic                      pkt_drop
);

  localparam int FLITS = PKT_W / CHIPDATA_WIDTH;
  localparam int CNT_W = (FLITS > 1) ? $clog2(FLITS) : 1;

  typedef enum logic [1:0] {IDLE, REQ, REL} state_t;

  state_t               state, state_nxt;
  logic [PKT_W-1:0]     shreg;
  logic [CNT_W-1:0]     idx;
  logic                 armed;   // ready has been seen low since entering REQ
  logic                 drop_q;
  logic                 last_flit;
  logic                 bad_eff;
  logic                 retry_left;

  assign last_flit = (idx == CNT_W'(FLITS-1));

`ifdef CLTX_RETRY_EN
  localparam int RW = $clog2(MAX_RETRY + 1);
  logic [RW-1:0] retry;
  logic          bad;

  assign bad_eff    = bad;
  assign retry_left = (retry < RW'(MAX_RETRY));

  // Error flag of the last ack and per-flit retransmission count
  always_ff @(posedge clk) begin
    if (rst) begin
      bad   <= 1'b0;
      retry <= '0;
    end else begin
      case (state)
        IDLE: if (pkt_valid) retry <= '0;
        REQ:  if (armed && send_data_ready) bad <= send_data_err;
        REL:  if (!send_data_ready) begin
                if (bad && retry_left) retry <= retry + 1'b1;
                else if (!bad)         retry <= '0;
              end
        default: ;
      endcase
    end
  end
`else
  logic unused_err;
  assign unused_err = send_data_err;
  assign bad_eff    = 1'b0;
  assign retry_left = 1'b1;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic for the four-phase handshake
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (pkt_valid) state_nxt = REQ;
      REQ:  if (armed && send_data_ready) state_nxt = REL;
      REL:  if (!send_data_ready) begin
              if (bad_eff && !retry_left) state_nxt = IDLE;
              else if (bad_eff)           state_nxt = REQ;
              else if (last_flit)         state_nxt = IDLE;
              else                        state_nxt = REQ;
            end
      default: state_nxt = IDLE;
    endcase
  end

  // Packet shift register, flit index, stale-ack guard and drop pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg  <= '0;
      idx    <= '0;
      armed  <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      drop_q <= 1'b0;
      case (state)
        IDLE: if (pkt_valid) begin
                shreg <= pkt_in;
                idx   <= '0;
                armed <= 1'b0;   // ready may still be high from an earlier ack
              end
        REQ:  if (!send_data_ready) armed <= 1'b1;
        REL:  if (!send_data_ready) begin
                armed <= 1'b1;   // ready is low on the way back into REQ
                if (bad_eff) begin
                  if (!retry_left) drop_q <= 1'b1;
                end else if (!last_flit) begin
                  shreg <= {shreg[PKT_W-CHIPDATA_WIDTH-1:0], {CHIPDATA_WIDTH{1'b0}}};
                  idx   <= idx + 1'b1;
                end
              end
        default: ;
      endcase
    end
  end

  assign pkt_ready       = (state == IDLE) && !rst;
  assign send_data_valid = (state == REQ);
  assign send_data_out   = shreg[PKT_W-1 -: CHIPDATA_WIDTH];
  assign send_data_par   = ^send_data_out;
  assign busy            = (state != IDLE);
  assign pkt_drop        = drop_q;

endmodule
